count_capture: RTL and testbench
================================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries; power of two, >= 2.
REQ-002 Parameter CW, default 4, width of the sampled count.
REQ-003 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock shared with the upstream counter.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 count_i  input  CW  free-running count from the upstream counter, sampled every clk edge.
REQ-007 cap_en  input  1  event detection enable; 0 suppresses new events.
REQ-008 cmp_val  input  CW  compare value for match events.
REQ-009 out_data  output  CW+2  head entry {wrap_flag, match_flag, count}, with wrap_flag as the MSB.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer accepts the head entry when out_valid=1.
REQ-012 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 clr_ovf  input  1  clears ovf.

Function
REQ-015 The block SHALL register count_i each cycle into prev_q, with a prev_valid_q bit that goes to 1 on the first cycle after reset.
REQ-016 Wrap event: prev_valid_q=1, prev_q=all-ones and count_i=0.
REQ-017 Match event: prev_valid_q=1, count_i==cmp_val and count_i!=prev_q, so a stalled count yields only one match.
REQ-018 Events SHALL be qualified by cap_en=1; with cap_en=0 nothing is pushed, but prev_q still updates.
REQ-019 When wrap and match occur in the same cycle, exactly one entry SHALL be pushed with both flags set.
REQ-020 Push data SHALL be {wrap, match, count_i} taken in the detection cycle.
REQ-021 Latency: an event detected at edge k SHALL appear at the head with out_valid=1 after edge k when the FIFO was empty; there is no combinational bypass.
REQ-022 A pop occurs at an edge where out_valid and out_ready are both 1; out_data and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Push while not full: the entry is stored and level increments unless a simultaneous pop occurs.
REQ-024 Push and pop in the same cycle SHALL both succeed, including when full; level is unchanged and ovf is not set.
REQ-025 Push while full without a pop: the entry is dropped, stored entries are unchanged, and ovf is set at that edge.
REQ-026 A pop when empty SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from level.
REQ-028 ovf SHALL be cleared by clr_ovf=1; if clr_ovf and a new overflow occur in the same cycle, ovf ends at 1.
REQ-029 out_data SHALL be don't-care when out_valid=0.

Reset
REQ-030 Under rst=1: out_valid=0, level=0, ovf=0, pointers=0, prev_valid_q=0, prev_q=0.
REQ-031 rst SHALL take priority over push, pop and clr_ovf in the same cycle; in-flight entries are discarded.
REQ-032 On the first edge after rst falls, no event SHALL be detected, because prev_valid_q is still 0.
REQ-033 FIFO storage contents SHALL NOT require reset.

Structure
REQ-034 Package count_pkg SHALL hold CW_DEFAULT=4 and a packed typedef cap_entry_t {wrap, match, count}.
REQ-035 A single sub-module, sync_fifo (parameters DEPTH and entry width, with push/pop/full/empty/level ports), SHALL implement the buffering; count_capture contains only detection, flag and overflow logic.

Verification
REQ-036 Bench SHALL cover: reset release, then count ramping 0..15..0 with cap_en=1, cmp_val=5, out_ready=1 -> entries {0,1,5}, then {1,0,0}; each appears one cycle after its count value.
REQ-037 Bench SHALL cover: cmp_val=0 at wrap 15->0 -> a single entry {1,1,0}, with level peaking at 1.
REQ-038 Bench SHALL cover: out_ready=0, cmp_val=3, with count running through six match events -> level=4, ovf=1, and the first four entries retained in order.
REQ-039 Bench SHALL cover: FIFO full with a push and pop in the same cycle -> level stays 4, ovf stays 0, and the oldest entry is popped.
REQ-040 Bench SHALL cover: count held at 7 for 5 cycles with cmp_val=7 -> exactly one match entry.
REQ-041 Bench SHALL cover: rst asserted with level=3 and out_valid=1 -> at the next edge out_valid=0 and level=0, and no event is detected on the first post-reset edge even if count_i=cmp_val.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and defaults for the count capture block.
package count_pkg;

  localparam int CW_DEFAULT = 4;

  typedef struct packed {
    logic                  wrap;
    logic                  match;
    logic [CW_DEFAULT-1:0] count;
  } cap_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are decoded from level.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot at the same edge, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/count_capture.sv
// Detects wrap and compare-match events on an upstream count and queues
// {wrap, match, count} entries for a consumer, with a sticky overflow flag.
module count_capture
  import count_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CW    = CW_DEFAULT,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count_i,
  input  logic          cap_en,
  input  logic [CW-1:0] cmp_val,
  output logic [CW+1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          ovf,
  input  logic          clr_ovf
);

  logic [CW-1:0] prev_q;
  logic          prev_valid_q;
  logic          wrap;
  logic          match;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign wrap  = prev_valid_q && (prev_q == '1) && (count_i == '0);
  // Requiring a change of count keeps a stalled counter from re-matching.
  assign match = prev_valid_q && (count_i == cmp_val) && (count_i != prev_q);
  assign push  = cap_en && (wrap || match);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_q       <= count_i;
      prev_valid_q <= 1'b1;
    end
  end

  // A new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                          ovf <= 1'b0;
    else if (push && full && !pop)    ovf <= 1'b1;
    else if (clr_ovf)                 ovf <= 1'b0;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (CW + 2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({wrap, match, count_i}),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: expected entries are queued as events are
// driven and compared whenever the consumer takes the head.
module tb_count_capture;
  import count_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count_i;
  logic          cap_en;
  logic [CW-1:0] cmp_val;
  logic [CW+1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          clr_ovf;

  int            checks = 0;
  int            errors = 0;
  int            maxlvl;
  logic [CW+1:0] sb [$];

  always #5 clk = ~clk;

  count_capture #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_i   (count_i),
    .cap_en    (cap_en),
    .cmp_val   (cmp_val),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  function automatic logic [CW+1:0] ent(logic w, logic m, logic [CW-1:0] c);
    cap_entry_t e;
    e.wrap  = w;
    e.match = m;
    e.count = c;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: take the head at the negedge if the consumer accepts it, then
  // advance past the next rising edge.
  task automatic cyc();
    logic [CW+1:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_entry: observed %0h expected none", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("entry", 32'(out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; count_i = '0; cap_en = 1'b0; cmp_val = '0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Ramp 0..15..0 with cmp_val=5
    cap_en = 1'b1; cmp_val = 4'd5; rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      count_i = 4'(i);
      if (i == 5)  sb.push_back(ent(1'b0, 1'b1, 4'd5));
      if (i == 16) sb.push_back(ent(1'b1, 1'b0, 4'd0));
      cyc();
      if (i == 0) chk("ramp_first_edge_no_event", 32'(out_valid), 0);
      if (i == 5) begin
        chk("ramp_match_valid", 32'(out_valid), 1);
        chk("ramp_match_data", 32'(out_data), 32'(ent(1'b0, 1'b1, 4'd5)));
      end
      if (i == 16) begin
        chk("ramp_wrap_valid", 32'(out_valid), 1);
        chk("ramp_wrap_data", 32'(out_data), 32'(ent(1'b1, 1'b0, 4'd0)));
      end
    end
    cyc(); cyc();
    chk("ramp_drained", 32'(level), 0);

    // Wrap and match together
    cmp_val = 4'd0; maxlvl = 0;
    for (int i = 1; i <= 16; i++) begin
      count_i = 4'(i);
      if (i == 16) sb.push_back(ent(1'b1, 1'b1, 4'd0));
      cyc();
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (i == 16) chk("both_data", 32'(out_data), 32'(ent(1'b1, 1'b1, 4'd0)));
    end
    cyc(); cyc();
    chk("both_level_peak", 32'(maxlvl), 1);
    chk("both_drained", 32'(level), 0);

    // Six matches with consumer stalled
    out_ready = 1'b0; cmp_val = 4'd3;
    for (int i = 0; i < 6; i++) begin
      count_i = 4'd3;
      cyc();
      if (i == 3) chk("ovf_before_drop", 32'(ovf), 0);
      if (i == 4) chk("ovf_on_drop", 32'(ovf), 1);
      count_i = 4'd4;
      cyc();
    end
    chk("ovf_level", 32'(level), 4);
    chk("ovf_sticky", 32'(ovf), 1);
    chk("ovf_head", 32'(out_data), 32'(ent(1'b0, 1'b1, 4'd3)));
    clr_ovf = 1'b1; count_i = 4'd3;
    cyc();
    chk("clr_vs_new_ovf", 32'(ovf), 1);
    count_i = 4'd4;
    cyc();
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_level", 32'(level), 4);
    clr_ovf = 1'b0;
    repeat (4) sb.push_back(ent(1'b0, 1'b1, 4'd3));
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("ovf_drained", 32'(level), 0);
    chk("ovf_sb_empty", 32'(sb.size()), 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cmp_val = 4'(i);
      count_i = 4'(i);
      sb.push_back(ent(1'b0, 1'b1, 4'(i)));
      cyc();
    end
    chk("full_level", 32'(level), 4);
    chk("full_head", 32'(out_data), 32'(ent(1'b0, 1'b1, 4'd1)));
    cyc();
    chk("full_head_stable", 32'(out_data), 32'(ent(1'b0, 1'b1, 4'd1)));
    chk("full_valid_stable", 32'(out_valid), 1);
    cmp_val = 4'd9; count_i = 4'd9; out_ready = 1'b1;
    sb.push_back(ent(1'b0, 1'b1, 4'd9));
    cyc();
    chk("pushpop_level", 32'(level), 4);
    chk("pushpop_ovf", 32'(ovf), 0);
    chk("pushpop_head", 32'(out_data), 32'(ent(1'b0, 1'b1, 4'd2)));
    repeat (5) cyc();
    chk("pushpop_drained", 32'(level), 0);

    // Stalled count at the compare value
    cmp_val = 4'd7; count_i = 4'd7;
    sb.push_back(ent(1'b0, 1'b1, 4'd7));
    repeat (5) cyc();
    count_i = 4'd8;
    cyc(); cyc();
    chk("stall_drained", 32'(level), 0);
    chk("stall_single_entry", 32'(sb.size()), 0);

    // Reset with entries in flight
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cmp_val = 4'(i);
      count_i = 4'(i);
      cyc();
    end
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1; count_i = 4'd5; cmp_val = 4'd5;
    cyc();
    chk("rst_flush_valid", 32'(out_valid), 0);
    chk("rst_flush_level", 32'(level), 0);
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    chk("post_rst_no_event", 32'(out_valid), 0);
    cyc();
    chk("post_rst_level", 32'(level), 0);
    chk("end_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
